// File: rtl/instruction_align.sv
// -----------------------------------------------------------------------------
// instruction_align
// Fetches 32-bit instruction words from memory, buffers them as halfwords and
// presents one aligned instruction at a time (16-bit compressed or 32-bit,
// possibly straddling two memory words) together with its byte PC.
//
// Ports
//   iCLK, iRST_N           clock, asynchronous active-low reset
//   iFLUSH, iFLUSH_PC      redirect request and target byte PC
//   oMEM_REQ, oMEM_ADDR    single-cycle word read request, word address PC[9:2]
//   iMEM_VALID, iMEM_DATA  read response (one outstanding request at a time)
//   oIR_VALID, oIR, oIR_C  aligned instruction, compressed flag
//   oPC                    byte PC of oIR
//   iIR_READY              consumer accepts oIR this cycle
//
// Fetch FSM
//   state | meaning
//   IDLE  | no request outstanding; issues one when buffer has room
//   WAIT  | request outstanding; next response is pushed into the buffer
//   DROP  | request outstanding but redirected; next response is discarded
// -----------------------------------------------------------------------------
module instruction_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iFLUSH,
    input  logic [31:0] iFLUSH_PC,
    output logic        oMEM_REQ,
    output logic [7:0]  oMEM_ADDR,
    input  logic        iMEM_VALID,
    input  logic [31:0] iMEM_DATA,
    output logic        oIR_VALID,
    output logic [31:0] oIR,
    output logic        oIR_C,
    output logic [31:0] oPC,
    input  logic        iIR_READY
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [2:0]  count_q, count_d;
    logic [15:0] fifo_q [4];
    logic [15:0] fifo_d [4];
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        misalign_q, misalign_d;

    logic        head_is_32;
    logic        ir_avail;
    logic        pop;
    logic [2:0]  pop_n;
    logic [2:0]  count_after_pop;
    logic [2:0]  push_n;
    logic [15:0] push_lo;
    logic [1:0]  wr_idx;

    assign head_is_32      = (fifo_q[0][1:0] == 2'b11);
    assign ir_avail        = head_is_32 ? (count_q >= 3'd2) : (count_q >= 3'd1);
    assign oIR_VALID       = ir_avail && !iFLUSH;
    assign oIR             = head_is_32 ? {fifo_q[1], fifo_q[0]} : {16'h0000, fifo_q[0]};
    assign oIR_C           = !head_is_32;
    assign oPC             = head_pc_q;
    assign oMEM_ADDR       = fetch_pc_q[9:2];

    assign pop             = oIR_VALID && iIR_READY;
    assign pop_n           = !pop ? 3'd0 : (head_is_32 ? 3'd2 : 3'd1);
    assign count_after_pop = count_q - pop_n;

    // Issuing only when at most two halfwords remain after this cycle's pop
    // guarantees room for a full word, so the buffer can never overflow.
    assign oMEM_REQ = iRST_N && (state_q == ST_IDLE) && !iFLUSH
                      && (count_after_pop <= 3'd2);

    // First word after a redirect to an odd halfword holds only the upper
    // halfword of interest.
    assign push_n  = ((state_q == ST_WAIT) && iMEM_VALID) ? (misalign_q ? 3'd1 : 3'd2) : 3'd0;
    assign push_lo = misalign_q ? iMEM_DATA[31:16] : iMEM_DATA[15:0];
    assign wr_idx  = count_after_pop[1:0];

    always_comb begin
        state_d    = state_q;
        count_d    = count_after_pop + push_n;
        head_pc_d  = head_pc_q + {28'd0, pop_n, 1'b0};
        fetch_pc_d = fetch_pc_q;
        misalign_d = misalign_q;

        for (int i = 0; i < 4; i++) begin
            fifo_d[i] = fifo_q[i];
        end
        if (pop_n == 3'd1) begin
            fifo_d[0] = fifo_q[1];
            fifo_d[1] = fifo_q[2];
            fifo_d[2] = fifo_q[3];
        end else if (pop_n == 3'd2) begin
            fifo_d[0] = fifo_q[2];
            fifo_d[1] = fifo_q[3];
        end
        if (push_n != 3'd0) begin
            fifo_d[wr_idx] = push_lo;
        end
        if (push_n == 3'd2) begin
            fifo_d[wr_idx + 2'd1] = iMEM_DATA[31:16];
        end

        case (state_q)
            ST_IDLE: begin
                if (oMEM_REQ) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (iMEM_VALID) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    misalign_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (iMEM_VALID) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (iFLUSH) begin
            count_d    = 3'd0;
            head_pc_d  = iFLUSH_PC & 32'hFFFF_FFFE;
            fetch_pc_d = iFLUSH_PC & 32'hFFFF_FFFC;
            misalign_d = iFLUSH_PC[1];
            // A response arriving in the flush cycle is the outstanding one;
            // it is discarded here, so there is nothing left to drop.
            if (state_q == ST_IDLE || iMEM_VALID) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_DROP;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= ST_IDLE;
            count_q    <= 3'd0;
            head_pc_q  <= RESET_PC & 32'hFFFF_FFFE;
            fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
            misalign_q <= RESET_PC[1];
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= 16'h0000;
            end
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            head_pc_q  <= head_pc_d;
            fetch_pc_q <= fetch_pc_d;
            misalign_q <= misalign_d;
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

endmodule

// File: tb/tb_instruction_align.sv
// -----------------------------------------------------------------------------
// tb_instruction_align
// Directed scenarios followed by randomized traffic. The expected instruction
// stream is derived from the program image by walking it halfword by halfword
// from the current PC; a monitor pops and compares every accepted instruction.
// -----------------------------------------------------------------------------
module tb_instruction_align;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        iCLK;
    logic        iRST_N;
    logic        iFLUSH;
    logic [31:0] iFLUSH_PC;
    logic        oMEM_REQ;
    logic [7:0]  oMEM_ADDR;
    logic        iMEM_VALID;
    logic [31:0] iMEM_DATA;
    logic        oIR_VALID;
    logic [31:0] oIR;
    logic        oIR_C;
    logic [31:0] oPC;
    logic        iIR_READY;

    instruction_align #(.RESET_PC(RESET_PC)) dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iFLUSH     (iFLUSH),
        .iFLUSH_PC  (iFLUSH_PC),
        .oMEM_REQ   (oMEM_REQ),
        .oMEM_ADDR  (oMEM_ADDR),
        .iMEM_VALID (iMEM_VALID),
        .iMEM_DATA  (iMEM_DATA),
        .oIR_VALID  (oIR_VALID),
        .oIR        (oIR),
        .oIR_C      (oIR_C),
        .oPC        (oPC),
        .iIR_READY  (iIR_READY)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        c;
    } exp_t;

    logic [15:0] mem16 [512];
    exp_t        exp_q [$];
    logic [31:0] model_pc;
    int          checks    = 0;
    int          failures  = 0;
    int          accepted  = 0;
    int          req_cnt   = 0;
    int          lat_min   = 1;
    int          lat_max   = 1;
    int          stale_req = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: the program is a stream of halfwords; a halfword with
    // low bits 11 starts a 32-bit instruction, anything else is compressed.
    task automatic refill();
        logic [15:0] lo, hi;
        logic [31:0] nxt;
        exp_t        e;
        while (exp_q.size() < 16) begin
            lo = mem16[model_pc[9:1]];
            e.pc = model_pc;
            if (lo[1:0] != 2'b11) begin
                e.ir = {16'h0000, lo};
                e.c  = 1'b1;
                model_pc = model_pc + 32'd2;
            end else begin
                nxt  = model_pc + 32'd2;
                hi   = mem16[nxt[9:1]];
                e.ir = {hi, lo};
                e.c  = 1'b0;
                model_pc = model_pc + 32'd4;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        model_pc = {pc[31:1], 1'b0};
        refill();
    endtask

    // Memory responder: one request tracked, fixed or random latency.
    // A response still pending at reset is delivered while reset is low.
    initial begin : memory
        logic       pend;
        logic [7:0] paddr;
        int         wait_left;
        int         stale_seen;
        pend = 1'b0; paddr = 8'h00; wait_left = 0; stale_seen = 0;
        iMEM_VALID = 1'b0;
        iMEM_DATA  = 32'h0;
        forever begin
            @(posedge iCLK);
            #2;
            iMEM_VALID = 1'b0;
            if (stale_req != stale_seen) begin
                stale_seen = stale_req;
                iMEM_VALID = 1'b1;
                iMEM_DATA  = 32'hDEAD_BEEF;
            end else if (pend) begin
                if (!iRST_N || wait_left == 0) begin
                    iMEM_VALID = 1'b1;
                    iMEM_DATA  = {mem16[{paddr, 1'b1}], mem16[{paddr, 1'b0}]};
                    pend = 1'b0;
                end else begin
                    wait_left--;
                end
            end
            @(negedge iCLK);
            if (iRST_N && oMEM_REQ) begin
                req_cnt++;
                check("req_overlap", 32'(pend), 32'd0);
                pend      = 1'b1;
                paddr     = oMEM_ADDR;
                wait_left = int'($urandom_range(lat_max, lat_min)) - 1;
            end
        end
    end

    // Monitor: compares every accepted instruction with the scoreboard head.
    initial begin : monitor
        logic        hold;
        logic [31:0] h_ir, h_pc;
        exp_t        e;
        hold = 1'b0; h_ir = 32'h0; h_pc = 32'h0;
        forever begin
            @(negedge iCLK);
            if (!iRST_N) begin
                hold = 1'b0;
            end else begin
                if (iFLUSH) begin
                    check("flush_valid_low", 32'(oIR_VALID), 32'd0);
                end else begin
                    if (hold) begin
                        check("hold_valid", 32'(oIR_VALID), 32'd1);
                        check("hold_ir", oIR, h_ir);
                        check("hold_pc", oPC, h_pc);
                    end
                    if (oIR_VALID && iIR_READY) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL sb_empty actual pc=%h ir=%h required=none", oPC, oIR);
                        end else begin
                            e = exp_q.pop_front();
                            check("sb_pc", oPC, e.pc);
                            check("sb_ir", oIR, e.ir);
                            check("sb_irc", 32'(oIR_C), 32'(e.c));
                            accepted++;
                        end
                    end
                end
                hold = oIR_VALID && !iIR_READY && !iFLUSH;
                h_ir = oIR;
                h_pc = oPC;
            end
        end
    end

    task automatic cyc();
        @(posedge iCLK);
        #1;
        refill();
    endtask

    task automatic reset_cycles(input int n);
        @(posedge iCLK);
        #1;
        iRST_N = 1'b0;
        iFLUSH = 1'b0;
        @(negedge iCLK);
        check("rst_req", 32'(oMEM_REQ), 32'd0);
        check("rst_valid", 32'(oIR_VALID), 32'd0);
        check("rst_pc", oPC, RESET_PC & 32'hFFFF_FFFE);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
        iRST_N = 1'b1;
        restart(RESET_PC);
    endtask

    task automatic expect_next(input string name, input logic [31:0] ir, input logic c,
                               input logic [31:0] pc, output int waited);
        waited = 0;
        @(negedge iCLK);
        while (!oIR_VALID && waited < 30) begin
            @(negedge iCLK);
            waited++;
        end
        check({name, "_valid"}, 32'(oIR_VALID), 32'd1);
        check({name, "_ir"}, oIR, ir);
        check({name, "_irc"}, 32'(oIR_C), 32'(c));
        check({name, "_pc"}, oPC, pc);
    endtask

    task automatic wait_req(input string name, input logic [7:0] addr);
        int n;
        n = 0;
        @(negedge iCLK);
        while (!oMEM_REQ && n < 30) begin
            @(negedge iCLK);
            n++;
        end
        check({name, "_req"}, 32'(oMEM_REQ), 32'd1);
        check({name, "_addr"}, 32'(oMEM_ADDR), 32'(addr));
    endtask

    task automatic fill_random();
        logic [15:0] hw;
        for (int i = 0; i < 512; i++) begin
            hw = 16'($urandom);
            if ($urandom_range(1, 0) == 1) hw[1:0] = 2'b11;
            mem16[i] = hw;
        end
    endtask

    initial begin : main
        int n;
        int r;
        iRST_N    = 1'b0;
        iFLUSH    = 1'b0;
        iFLUSH_PC = 32'h0;
        iIR_READY = 1'b1;
        fill_random();
        model_pc  = RESET_PC;

        // Single 32-bit instruction, 1-cycle memory latency
        mem16[0] = 16'h0513; mem16[1] = 16'h4501;
        reset_cycles(2);
        @(negedge iCLK);
        check("r031_req", 32'(oMEM_REQ), 32'd1);
        check("r031_addr", 32'(oMEM_ADDR), 32'd0);
        expect_next("r031", 32'h4501_0513, 1'b0, 32'h0, n);
        check("r031_lat", 32'(n), 32'd1);

        // Two compressed instructions in one word
        mem16[0] = 16'h4501; mem16[1] = 16'h4108;
        reset_cycles(1);
        expect_next("r032a", 32'h0000_4501, 1'b1, 32'h0, n);
        expect_next("r032b", 32'h0000_4108, 1'b1, 32'h2, n);

        // 32-bit instruction straddling two words
        mem16[0] = 16'h4501; mem16[1] = 16'h0513;
        mem16[2] = 16'h0045; mem16[3] = 16'h4781;
        reset_cycles(1);
        expect_next("r033a", 32'h0000_4501, 1'b1, 32'h0, n);
        expect_next("r033b", 32'h0045_0513, 1'b0, 32'h2, n);
        expect_next("r033c", 32'h0000_4781, 1'b1, 32'h6, n);

        // Redirect to an odd halfword while a request is outstanding
        lat_min = 3; lat_max = 3;
        mem16[8] = 16'h1234; mem16[9] = 16'h4501;
        reset_cycles(1);
        @(negedge iCLK);
        check("r034_first_req", 32'(oMEM_REQ), 32'd1);
        cyc();
        iFLUSH = 1'b1; iFLUSH_PC = 32'h0000_0012;
        restart(iFLUSH_PC);
        cyc();
        iFLUSH = 1'b0;
        wait_req("r034", 8'h04);
        expect_next("r034", 32'h0000_4501, 1'b1, 32'h12, n);

        // Consumer stalled: buffer fills to four halfwords, then stops fetching
        lat_min = 1; lat_max = 1;
        iIR_READY = 1'b0;
        reset_cycles(1);
        r = req_cnt;
        repeat (12) cyc();
        @(negedge iCLK);
        check("r035_reqs", 32'(req_cnt - r), 32'd2);
        check("r035_valid", 32'(oIR_VALID), 32'd1);
        check("r035_pc", oPC, 32'h0);
        cyc();
        iFLUSH = 1'b1; iFLUSH_PC = 32'h0000_0040;
        restart(iFLUSH_PC);
        cyc();
        iFLUSH = 1'b0;
        @(negedge iCLK);
        check("r025_req", 32'(oMEM_REQ), 32'd1);
        check("r025_addr", 32'(oMEM_ADDR), 32'h10);
        iIR_READY = 1'b1;

        // Reset pulse during an outstanding request, stale response afterwards
        lat_min = 2; lat_max = 2;
        mem16[0] = 16'h4501; mem16[1] = 16'h4108;
        reset_cycles(1);
        cyc();
        iRST_N = 1'b0;
        cyc();
        iRST_N = 1'b1;
        restart(RESET_PC);
        stale_req++;
        @(negedge iCLK);
        check("r036_req", 32'(oMEM_REQ), 32'd1);
        check("r036_addr", 32'(oMEM_ADDR), 32'd0);
        check("r036_valid0", 32'(oIR_VALID), 32'd0);
        cyc();
        @(negedge iCLK);
        check("r036_valid1", 32'(oIR_VALID), 32'd0);
        expect_next("r036", 32'h0000_4501, 1'b1, 32'h0, n);

        // Randomized traffic with flushes (including PC wrap) and resets
        fill_random();
        lat_min = 1; lat_max = 4;
        reset_cycles(1);
        r = accepted;
        for (int i = 0; i < 4000; i++) begin
            cyc();
            iFLUSH    = 1'b0;
            iIR_READY = ($urandom_range(9, 0) < 7);
            if (!iRST_N) begin
                iRST_N = 1'b1;
                restart(RESET_PC);
            end else begin
                n = int'($urandom_range(199, 0));
                if (n < 6) begin
                    iFLUSH = 1'b1;
                    if (n < 2) iFLUSH_PC = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
                    else       iFLUSH_PC = $urandom;
                    restart(iFLUSH_PC);
                end else if (n == 6) begin
                    iRST_N = 1'b0;
                end
            end
        end
        iFLUSH = 1'b0;
        iRST_N = 1'b1;
        repeat (4) cyc();
        check("progress", 32'(accepted - r > 1000), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_align.md
INSTRUCTION_ALIGN -- requirements
Module: instruction_align

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte PC fetched first after reset (bit 0 ignored).
REQ-002 SHALL have input iCLK, 1 bit: single clock; all state on rising edge.
REQ-003 SHALL have input iRST_N, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have inputs iFLUSH (1 bit) and iFLUSH_PC (32 bits): redirect request and its target byte PC.
REQ-005 SHALL have output oMEM_REQ, 1 bit: single-cycle instruction-word read request.
REQ-006 SHALL have output oMEM_ADDR, 8 bits: word address, fetch PC[9:2].
REQ-007 SHALL have inputs iMEM_VALID (1 bit) and iMEM_DATA (32 bits): read response, any latency of 1 cycle or more.
REQ-008 SHALL have output oIR_VALID, 1 bit: oIR, oIR_C and oPC valid.
REQ-009 SHALL have output oIR, 32 bits: instruction; compressed = {16'h0, halfword}.
REQ-010 SHALL have output oIR_C, 1 bit: oIR[1:0] != 2'b11, i.e. 16-bit instruction for the rv32c decoders.
REQ-011 SHALL have output oPC, 32 bits: byte PC of oIR.
REQ-012 SHALL have input iIR_READY, 1 bit: consumer accepts oIR this cycle.

Function
REQ-013 SHALL hold a halfword FIFO of 4 entries, count 0..4; head halfword = lowest PC.
REQ-014 SHALL drive oIR_VALID when count>=1 and head[1:0]!=2'b11, or count>=2 and head[1:0]==2'b11; otherwise 0.
REQ-015 SHALL form a 32-bit oIR as {entry1, entry0}; outputs combinational from FIFO and PC registers.
REQ-016 SHALL pop 1 (compressed) or 2 (32-bit) halfwords and add 2 or 4 to the head PC when oIR_VALID && iIR_READY.
REQ-017 SHALL use fetch FSM states IDLE, WAIT, DROP.
REQ-018 IDLE: if count after this cycle's pop is <=2 and no flush, SHALL pulse oMEM_REQ for one cycle with oMEM_ADDR = fetch PC[9:2], then go to WAIT.
REQ-019 WAIT: on iMEM_VALID SHALL push halfwords, add 4 to the word-aligned fetch PC, and return to IDLE; next request no earlier than the following cycle.
REQ-020 SHALL push both halfwords (low first) of a response, except the first response after a redirect to a PC with bit 1 = 1: push only iMEM_DATA[31:16].
REQ-021 SHALL allow pop and push in the same cycle; new count = count - pop + push; never exceeds 4 because of the REQ-018 issue rule.
REQ-022 iFLUSH SHALL have priority over pop, push and request: clear count to 0, head PC = {iFLUSH_PC[31:1],1'b0}, fetch PC = {iFLUSH_PC[31:2],2'b00}, set misalign flag = iFLUSH_PC[1].
REQ-023 iFLUSH in WAIT SHALL move to DROP; DROP SHALL discard the next iMEM_VALID response, then go to IDLE.
REQ-024 iFLUSH in DROP SHALL stay in DROP and apply the new PC; iFLUSH in IDLE SHALL stay in IDLE.
REQ-025 SHALL hold oIR_VALID low during the flush cycle; the first post-flush request SHALL issue the cycle after the flush.
REQ-026 SHALL ignore iMEM_VALID in IDLE.
REQ-027 SHALL wrap PC arithmetic modulo 2^32; oMEM_ADDR wraps 8'hFF -> 8'h00.
REQ-028 SHALL keep oIR/oPC stable while oIR_VALID=1 and iIR_READY=0, unless flushed.

Reset
REQ-029 While iRST_N=0 SHALL force: state IDLE, count 0, head PC = {RESET_PC[31:1],0}, fetch PC = {RESET_PC[31:2],00}, misalign = RESET_PC[1], oMEM_REQ=0, oIR_VALID=0.
REQ-030 SHALL treat reset mid-request as abandoning it; responses during reset are ignored; first request issues the first cycle after release.

Verification
REQ-031 Reset release, RESET_PC=0, memory word 0 = 32'h4501_0513 with 1-cycle latency, iIR_READY=1 -> oMEM_REQ with addr 0 in cycle 1; oIR_VALID=1, oIR=32'h4501_0513, oIR_C=0, oPC=0.
REQ-032 Word 0 = 32'h4108_4501 -> oIR=32'h0000_4501 (oIR_C=1, oPC=0), then oIR=32'h0000_4108 (oIR_C=1, oPC=2).
REQ-033 32-bit instruction straddling words: word0 = 32'h0513_4501, word1 = 32'h4781_0045 -> 16'h4501 at PC 0, then 32'h0045_0513 at PC 2, then 16'h4781 at PC 6.
REQ-034 iFLUSH with iFLUSH_PC=32'h0000_0012 while in WAIT -> pending response discarded; next oMEM_ADDR=8'h04; only the upper halfword of the returned word is pushed; first oPC=32'h12.
REQ-035 iIR_READY=0 for 10 cycles -> at most 4 halfwords buffered, no oMEM_REQ while count>2, oIR/oPC unchanged.
REQ-036 iRST_N low for one cycle during WAIT, then the stale iMEM_VALID -> no push, restart at RESET_PC, oIR_VALID=0 until a new response.
